// File: rtl/pipe_sequencer_ctrl.sv
// Front-end sequencer: decides PC / IF-ID / downstream enables, NOP-select and bubble
// each cycle, under continuous or single-step debug control, with halt-drain handling.
module pipe_sequencer_ctrl #(
  parameter int unsigned       NB_DATA      = 32,
  parameter int unsigned       N_BITS_OP    = 6,
  parameter int unsigned       NB_CMD       = 8,
  parameter logic [NB_CMD-1:0] CMD_STEP     = 8'h0F,
  parameter logic [NB_CMD-1:0] CMD_CONT     = 8'hF0,
  parameter logic [N_BITS_OP-1:0] HALT_OPCODE = 6'h3F,
  parameter int unsigned       DRAIN_CYCLES = 4,
  parameter int unsigned       NB_CYCLES    = 32
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 cmd_valid_i,
  input  logic [NB_CMD-1:0]    cmd_i,
  input  logic                 step_i,
  input  logic [NB_DATA-1:0]   instr_if_id_i,
  input  logic                 load_use_hazard_i,
  input  logic                 jump_or_branch_i,
  output logic                 enable_pc_o,
  output logic                 enable_if_id_o,
  output logic                 flush_if_id_o,
  output logic                 enable_pipe_o,
  output logic                 bubble_id_ex_o,
  output logic                 running_o,
  output logic                 halted_o,
  output logic                 step_done_o,
  output logic [NB_CYCLES-1:0] cycle_count_o
);

  localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    HALTED    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  draining_q, draining_d;
  logic [NB_DRAIN-1:0]   drain_cnt_q, drain_cnt_d;
  logic [NB_CYCLES-1:0]  cycle_count_q, cycle_count_d;
  logic                  step_done_q;
  logic                  exec;
  logic                  drain_done;
  logic                  halt_in_if_id;
  logic                  cmd_cont;
  logic                  cmd_step;
  logic                  unused_instr_bits;

  // Only the opcode field of the IF/ID word matters here.
  assign halt_in_if_id     = (instr_if_id_i[NB_DATA-1 -: N_BITS_OP] == HALT_OPCODE);
  assign unused_instr_bits = ^instr_if_id_i[NB_DATA-N_BITS_OP-1:0];

  assign cmd_cont = cmd_valid_i && (cmd_i == CMD_CONT);
  assign cmd_step = cmd_valid_i && (cmd_i == CMD_STEP);

  // State, drain tracking, step-done pulse and executed-cycle counter.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      draining_q    <= 1'b0;
      drain_cnt_q   <= '0;
      cycle_count_q <= '0;
      step_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      draining_q    <= draining_d;
      drain_cnt_q   <= drain_cnt_d;
      cycle_count_q <= cycle_count_d;
      step_done_q   <= (state_q == STEP_EXEC);
    end
  end

  // Exec-cycle decode and next-state logic.
  always_comb begin
    state_d        = state_q;
    draining_d     = draining_q;
    drain_cnt_d    = drain_cnt_q;
    cycle_count_d  = cycle_count_q;
    enable_pc_o    = 1'b0;
    enable_if_id_o = 1'b0;
    flush_if_id_o  = 1'b0;
    enable_pipe_o  = 1'b0;
    bubble_id_ex_o = 1'b0;
    drain_done     = 1'b0;
    exec           = (state_q == RUN) || (state_q == STEP_EXEC);

    if (exec) begin
      if (draining_q) begin
        enable_if_id_o = 1'b1;
        flush_if_id_o  = 1'b1;
        enable_pipe_o  = 1'b1;
        if (drain_cnt_q != '0) begin
          drain_cnt_d = drain_cnt_q - NB_DRAIN'(1);
        end else begin
          drain_done = 1'b1;
        end
      end else if (halt_in_if_id) begin
        // Freeze fetch and feed NOPs so the halt flows out of the pipe.
        enable_if_id_o = 1'b1;
        flush_if_id_o  = 1'b1;
        enable_pipe_o  = 1'b1;
        draining_d     = 1'b1;
        drain_cnt_d    = NB_DRAIN'(DRAIN_CYCLES - 1);
      end else if (jump_or_branch_i) begin
        enable_pc_o    = 1'b1;
        enable_if_id_o = 1'b1;
        flush_if_id_o  = 1'b1;
        enable_pipe_o  = 1'b1;
      end else if (load_use_hazard_i) begin
        bubble_id_ex_o = 1'b1;
        enable_pipe_o  = 1'b1;
      end else begin
        enable_pc_o    = 1'b1;
        enable_if_id_o = 1'b1;
        enable_pipe_o  = 1'b1;
      end
    end

    if (enable_pipe_o && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + NB_CYCLES'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_cont) begin
          state_d = RUN;
        end else if (cmd_step) begin
          state_d = STEP_WAIT;
        end
      end
      RUN: begin
        if (drain_done) begin
          state_d = HALTED;
        end else if (cmd_step) begin
          state_d = STEP_WAIT;
        end
      end
      STEP_WAIT: begin
        // Any command in the same cycle as a step request swallows the step.
        if (cmd_valid_i) begin
          if (cmd_cont) begin
            state_d = RUN;
          end
        end else if (step_i) begin
          state_d = STEP_EXEC;
        end
      end
      STEP_EXEC: begin
        state_d = drain_done ? HALTED : STEP_WAIT;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign running_o     = (state_q == RUN) || (state_q == STEP_EXEC);
  assign halted_o      = (state_q == HALTED);
  assign step_done_o   = step_done_q;
  assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_pipe_sequencer_ctrl.sv
// Directed bench for pipe_sequencer_ctrl: the driver queues the expected per-cycle
// outputs, a separate monitor pops and compares them on the falling edge.
module tb_pipe_sequencer_ctrl;

  localparam int unsigned NB_CYC = 4;  // narrow counter so saturation is reached

  localparam logic [7:0] E_IDLE = 8'b0000_0000;
  localparam logic [7:0] E_RUN  = 8'b1101_0100;
  localparam logic [7:0] E_HAZ  = 8'b0001_1100;
  localparam logic [7:0] E_BR   = 8'b1111_0100;
  localparam logic [7:0] E_DRN  = 8'b0111_0100;
  localparam logic [7:0] E_HALT = 8'b0000_0010;
  localparam logic [7:0] E_SD   = 8'b0000_0001;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] LW   = 32'h8C08_0000;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  typedef struct {
    string             name;
    logic [7:0]        e;
    logic [NB_CYC-1:0] cc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [7:0]        cmd = '0;
  logic              step = 1'b0;
  logic [31:0]       instr = NOP;
  logic              hazard = 1'b0;
  logic              jb = 1'b0;
  logic              en_pc, en_ifid, flush, en_pipe, bubble, running, halted, step_done;
  logic [NB_CYC-1:0] cycle_count;

  exp_t              sb[$];
  logic [NB_CYC-1:0] exp_cc = '0;
  int                vectors = 0;
  int                miscompares = 0;

  always #5 clk = ~clk;

  pipe_sequencer_ctrl #(.NB_CYCLES(NB_CYC)) dut (
    .clock_i           (clk),
    .reset_i           (rst),
    .cmd_valid_i       (cmd_valid),
    .cmd_i             (cmd),
    .step_i            (step),
    .instr_if_id_i     (instr),
    .load_use_hazard_i (hazard),
    .jump_or_branch_i  (jb),
    .enable_pc_o       (en_pc),
    .enable_if_id_o    (en_ifid),
    .flush_if_id_o     (flush),
    .enable_pipe_o     (en_pipe),
    .bubble_id_ex_o    (bubble),
    .running_o         (running),
    .halted_o          (halted),
    .step_done_o       (step_done),
    .cycle_count_o     (cycle_count)
  );

  // e = {pc, if_id, flush, pipe, bubble, running, halted, step_done}
  task automatic apply(input string nm, input logic r, input logic cv, input logic [7:0] c,
                       input logic st, input logic [31:0] ins, input logic hz,
                       input logic j, input logic [7:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; cmd_valid = cv; cmd = c; step = st; instr = ins; hazard = hz; jb = j;
    if (r) exp_cc = '0;
    x.name = nm;
    x.e    = e;
    x.cc   = exp_cc;
    sb.push_back(x);
    if (e[4] && (exp_cc != '1)) exp_cc = exp_cc + NB_CYC'(1);
  endtask

  task automatic idle(input string nm, input logic [7:0] e);
    apply(nm, 1'b0, 1'b0, 8'h00, 1'b0, NOP, 1'b0, 1'b0, e);
  endtask

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  initial begin
    exp_t       x;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x   = sb.pop_front();
        act = {en_pc, en_ifid, flush, en_pipe, bubble, running, halted, step_done};
        vectors++;
        if ((act !== x.e) || (cycle_count !== x.cc)) begin
          miscompares++;
          $display("FAIL %s: got flags=%b count=%0d, want flags=%b count=%0d",
                   x.name, act, cycle_count, x.e, x.cc);
        end
      end
    end
  end

  initial begin
    // T1: reset and entry into continuous mode
    apply("reset",        1'b1, 1'b0, 8'h00, 1'b0, NOP, 1'b0, 1'b0, E_IDLE);
    idle("idle",          E_IDLE);
    apply("idle_badcmd",  1'b0, 1'b1, 8'h55, 1'b0, NOP, 1'b0, 1'b0, E_IDLE);
    apply("idle_step",    1'b0, 1'b0, 8'h00, 1'b1, NOP, 1'b0, 1'b0, E_IDLE);
    apply("cmd_cont",     1'b0, 1'b1, 8'hF0, 1'b0, NOP, 1'b0, 1'b0, E_IDLE);
    idle("run1",          E_RUN);
    // T2: load-use stall
    apply("run2",         1'b0, 1'b0, 8'h00, 1'b0, LW,  1'b0, 1'b0, E_RUN);
    apply("load_use",     1'b0, 1'b0, 8'h00, 1'b0, LW,  1'b1, 1'b0, E_HAZ);
    idle("after_hazard",  E_RUN);
    // T3: branch beats hazard
    apply("br_hazard",    1'b0, 1'b0, 8'h00, 1'b0, LW,  1'b1, 1'b1, E_BR);
    apply("br_only",      1'b0, 1'b0, 8'h00, 1'b0, NOP, 1'b0, 1'b1, E_BR);
    // T4: step mode
    apply("cmd_step",     1'b0, 1'b1, 8'h0F, 1'b0, NOP, 1'b0, 1'b0, E_RUN);
    idle("wait0",         E_IDLE);
    apply("step_req1",    1'b0, 1'b0, 8'h00, 1'b1, NOP, 1'b0, 1'b0, E_IDLE);
    idle("exec1",         E_RUN);
    apply("step_req2",    1'b0, 1'b0, 8'h00, 1'b1, NOP, 1'b0, 1'b0, E_SD);
    idle("exec2",         E_RUN);
    idle("done2",         E_SD);
    apply("step_and_cmd", 1'b0, 1'b1, 8'h0F, 1'b1, NOP, 1'b0, 1'b0, E_IDLE);
    idle("no_exec",       E_IDLE);
    apply("step_req3",    1'b0, 1'b0, 8'h00, 1'b1, NOP, 1'b0, 1'b0, E_IDLE);
    idle("exec3",         E_RUN);
    idle("done3",         E_SD);
    idle("wait_quiet",    E_IDLE);
    apply("cmd_cont2",    1'b0, 1'b1, 8'hF0, 1'b0, NOP, 1'b0, 1'b0, E_IDLE);
    idle("run3",          E_RUN);
    // T5: halt detect, four drain cycles, counter saturates at all-ones, then HALTED
    apply("halt_detect",  1'b0, 1'b0, 8'h00, 1'b0, HALT, 1'b0, 1'b0, E_DRN);
    apply("drain1_br",    1'b0, 1'b0, 8'h00, 1'b0, NOP, 1'b0, 1'b1, E_DRN);
    apply("drain2_hz",    1'b0, 1'b0, 8'h00, 1'b0, NOP, 1'b1, 1'b0, E_DRN);
    idle("drain3",        E_DRN);
    idle("drain4",        E_DRN);
    idle("halted",        E_HALT);
    apply("halted_cmd",   1'b0, 1'b1, 8'hF0, 1'b0, NOP, 1'b0, 1'b0, E_HALT);
    apply("halted_step",  1'b0, 1'b0, 8'h00, 1'b1, NOP, 1'b0, 1'b0, E_HALT);
    // T6: reset out of HALTED, then reset in the middle of a drain
    apply("reset2",       1'b1, 1'b0, 8'h00, 1'b0, NOP, 1'b0, 1'b0, E_IDLE);
    idle("idle2",         E_IDLE);
    apply("cmd_cont3",    1'b0, 1'b1, 8'hF0, 1'b0, NOP, 1'b0, 1'b0, E_IDLE);
    idle("run4",          E_RUN);
    apply("halt2",        1'b0, 1'b0, 8'h00, 1'b0, HALT, 1'b0, 1'b0, E_DRN);
    idle("drain_b1",      E_DRN);
    apply("reset_mid",    1'b1, 1'b0, 8'h00, 1'b0, NOP, 1'b0, 1'b0, E_IDLE);
    idle("idle3",         E_IDLE);
    apply("cmd_cont4",    1'b0, 1'b1, 8'hF0, 1'b0, NOP, 1'b0, 1'b0, E_IDLE);
    idle("run_clean",     E_RUN);
    idle("run_clean2",    E_RUN);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
